// File: rtl/serial_tx_ctrl_if.sv
// Handshake, configuration and serial-output bundle for serial_tx_ctrl.
// The master side supplies words and the bit period; the slave side drives the serial line.
interface serial_tx_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] period;
  logic             o;
  logic             o_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_data, in_valid, period,
    input  in_ready, o, o_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  in_data, in_valid, period,
    output in_ready, o, o_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/serial_tx_ctrl.sv
// Parallel-to-serial frame sequencer with programmable bit period and a one-word
// holding buffer so consecutive frames leave with no idle gap.
module serial_tx_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input logic             clk,
  input logic             clear,
  serial_tx_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;

  logic             xfer;
  logic             bit_end;
  logic             frame_end;
  logic             load;
  logic [WIDTH-1:0] load_word;

  assign bus.in_ready    = ~buf_full_q;
  assign bus.o           = o_q;
  assign bus.o_valid     = o_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = (state_q == StShift);

  always_comb begin
    xfer      = bus.in_valid & ~buf_full_q;
    bit_end   = (state_q == StShift) && (div_cnt_q == period_q);
    frame_end = bit_end && (bit_cnt_q == LastBit);

    state_d    = state_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    period_d   = period_q;
    load       = 1'b0;
    load_word  = bus.in_data;

    if (state_q == StIdle) begin
      load = xfer;
    end else if (frame_end) begin
      // Buffered word wins; otherwise a word arriving on this edge bypasses the buffer.
      if (buf_full_q) begin
        load       = 1'b1;
        load_word  = buf_q;
        buf_full_d = 1'b0;
      end else if (xfer) begin
        load = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end else begin
      if (bit_end) begin
        div_cnt_d = '0;
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (MSB_FIRST != 0) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      if (xfer) begin
        buf_d      = bus.in_data;
        buf_full_d = 1'b1;
      end
    end

    if (load) begin
      shreg_d   = load_word;
      period_d  = bus.period;
      bit_cnt_d = '0;
      div_cnt_d = '0;
      state_d   = StShift;
    end

    // Outputs are registered: derive them from the next-state values.
    o_valid_d     = (state_d == StShift);
    o_d           = o_valid_d & ((MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0]);
    frame_start_d = load;
    frame_done_d  = o_valid_d && (div_cnt_d == period_d) && (bit_cnt_d == LastBit);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      period_q      <= '0;
      o_q           <= 1'b0;
      o_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      bit_cnt_q     <= bit_cnt_d;
      div_cnt_q     <= div_cnt_d;
      period_q      <= period_d;
      o_q           <= o_d;
      o_valid_q     <= o_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule
